// File: rtl/key_voice_allocator_if.sv
// key_voice_allocator_if: bundles the held-key bitmap and per-voice outputs of the voice scheduler.
// Latency: none; this is wiring only.
// Backpressure: none; the bitmap is level-sampled and the voice outputs are plain state.
interface key_voice_allocator_if #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 32
);
  localparam int IDX_W = $clog2(KEY_W);

  logic [KEY_W-1:0]            i_key;
  logic [NUM_VOICES*IDX_W-1:0] o_voice_key;
  logic [NUM_VOICES-1:0]       o_voice_gate;
  logic [NUM_VOICES-1:0]       o_note_on;
  logic                        o_busy;
  logic                        o_drop;

  // Keyboard-decoder side: drives the bitmap, observes the voices.
  modport master (
    output i_key,
    input  o_voice_key, o_voice_gate, o_note_on, o_busy, o_drop
  );

  // Allocator side.
  modport slave (
    input  i_key,
    output o_voice_key, o_voice_gate, o_note_on, o_busy, o_drop
  );
endinterface

// File: rtl/key_voice_allocator.sv
// key_voice_allocator: assigns newly pressed keys to NUM_VOICES voice slots, frees them on release.
// Latency: one key per cycle, scan = KEY_W+1 cycles; change on i_key to note_on <= 2*KEY_W+3 cycles.
// Backpressure: none; i_key changes during a scan wait for the next scan. Build macro VOICE_STEAL_EN.
module key_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 32,
  parameter int STAMP_W    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  key_voice_allocator_if.slave  bus
);
  localparam int IDX_W = $clog2(KEY_W);
  localparam int VID_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [VID_W-1:0]   vid_t;
  typedef logic [STAMP_W-1:0] stamp_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                state, state_nxt;
  logic [KEY_W-1:0]      committed;
  logic [KEY_W-1:0]      snap;
  idx_t                  idx;
  idx_t                  voice_key [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate;
  logic [NUM_VOICES-1:0] note_on;
  logic                  drop;

  logic                  press_bit;
  logic                  release_bit;
  logic                  free_found;
  vid_t                  free_v;
  logic [NUM_VOICES-1:0] rel_hit;

`ifdef VOICE_STEAL_EN
  // Age bookkeeping only matters when a busy voice may be stolen.
  stamp_t                stamp [NUM_VOICES];
  stamp_t                stamp_cnt;
  stamp_t                age;
  stamp_t                best_age;
  vid_t                  old_v;
`endif

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: idle until the bitmap differs from what was acted on, then sweep all keys.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_key != committed) state_nxt = SCAN;
      SCAN:    if (idx == idx_t'(KEY_W-1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Current key's event and voice search; the reverse sweep leaves the lowest free voice.
  always_comb begin
    press_bit   = snap[idx] & ~committed[idx];
    release_bit = ~snap[idx] & committed[idx];
    free_found  = 1'b0;
    free_v      = '0;
    rel_hit     = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!gate[v]) begin
        free_found = 1'b1;
        free_v     = vid_t'(v);
      end
      rel_hit[v] = gate[v] && (voice_key[v] == idx);
    end
  end

`ifdef VOICE_STEAL_EN
  // Oldest gated voice: largest wrapped age, strict compare keeps the lowest index on ties.
  always_comb begin
    old_v    = '0;
    best_age = '0;
    age      = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      age = stamp_cnt - stamp[v];
      if (v == 0 || age > best_age) begin
        best_age = age;
        old_v    = vid_t'(v);
      end
    end
  end
`endif

  // Scan datapath: snapshot, per-key release/allocate, commit at the end of the sweep.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      committed <= '0;
      snap      <= '0;
      idx       <= '0;
      gate      <= '0;
      note_on   <= '0;
      drop      <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) voice_key[v] <= '0;
`ifdef VOICE_STEAL_EN
      stamp_cnt <= '0;
      for (int v = 0; v < NUM_VOICES; v++) stamp[v] <= '0;
`endif
    end else begin
      note_on <= '0;
      drop    <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_key != committed) begin
            snap <= bus.i_key;
            idx  <= '0;
          end
        end
        SCAN: begin
          if (release_bit) begin
            gate <= gate & ~rel_hit;
          end else if (press_bit) begin
            if (free_found) begin
              voice_key[free_v] <= idx;
              gate[free_v]      <= 1'b1;
              note_on[free_v]   <= 1'b1;
`ifdef VOICE_STEAL_EN
              stamp[free_v]     <= stamp_cnt;
              stamp_cnt         <= stamp_cnt + 1'b1;
`endif
            end else begin
`ifdef VOICE_STEAL_EN
              // Retrigger the oldest voice on the new key; its gate is already high.
              voice_key[old_v]  <= idx;
              note_on[old_v]    <= 1'b1;
              stamp[old_v]      <= stamp_cnt;
              stamp_cnt         <= stamp_cnt + 1'b1;
`else
              // Discarded press still gets committed, so it stays silent until re-pressed.
              drop              <= 1'b1;
`endif
            end
          end
          idx <= idx + 1'b1;
        end
        DONE: committed <= snap;
        default: ;
      endcase
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_vkey
    assign bus.o_voice_key[v*IDX_W +: IDX_W] = voice_key[v];
  end

  assign bus.o_voice_gate = gate;
  assign bus.o_note_on    = note_on;
  assign bus.o_drop       = drop;
  assign bus.o_busy       = (state != IDLE);

endmodule

// File: tb/tb_key_voice_allocator.sv
// tb_key_voice_allocator: directed vectors for the voice scheduler, 4 voices on a 32-key bitmap.
// Latency: each vector waits for one full scan (33 busy cycles) before comparing.
// Backpressure: none; every wait on the DUT is bounded.
module tb_key_voice_allocator;
  localparam int NV = 4;
  localparam int KW = 32;

  typedef struct {
    logic [31:0] key;
    logic [19:0] vkey;
    logic [3:0]  gate;
    logic [3:0]  note;
    int          drop;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   busy_cnt;
  int   note_cnt;
  int   drop_cnt;
  logic [3:0] note_acc;
  bit   timed_out;
  int   note_cyc [NV];
  vec_t vecs [8];

  key_voice_allocator_if #(.NUM_VOICES(NV), .KEY_W(KW)) bus ();

  key_voice_allocator #(.NUM_VOICES(NV), .KEY_W(KW), .STAMP_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {d[4:0], c[4:0], b[4:0], a[4:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Drive a new bitmap and watch one complete scan, collecting pulses and their cycle offsets.
  task automatic apply(input logic [31:0] k);
    int w;
    @(posedge clk);
    #1 bus.i_key = k;
    busy_cnt  = 0;
    note_cnt  = 0;
    drop_cnt  = 0;
    note_acc  = '0;
    timed_out = 1'b0;
    for (int v = 0; v < NV; v++) note_cyc[v] = -1;
    @(negedge clk);
    w = 0;
    while (!bus.o_busy && w < 5) begin
      @(negedge clk);
      w++;
    end
    if (!bus.o_busy) begin
      timed_out = 1'b1;
    end else begin
      w = 0;
      while (bus.o_busy && w < 40) begin
        for (int v = 0; v < NV; v++) begin
          if (bus.o_note_on[v]) begin
            if (note_cyc[v] < 0) note_cyc[v] = busy_cnt;
            note_cnt++;
          end
        end
        note_acc = note_acc | bus.o_note_on;
        if (bus.o_drop) drop_cnt++;
        busy_cnt++;
        w++;
        @(negedge clk);
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vkey"}, 64'(bus.o_voice_key), 64'h0);
    chk({tag, "_gate"}, 64'(bus.o_voice_gate), 64'h0);
    chk({tag, "_note"}, 64'(bus.o_note_on), 64'h0);
    chk({tag, "_busy"}, 64'(bus.o_busy), 64'h0);
    chk({tag, "_drop"}, 64'(bus.o_drop), 64'h0);
  endtask

  initial begin
    int idle_busy;
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{32'h0000_0001, pk(0, 0, 0, 0), 4'b0001, 4'b0001, 0};
    vecs[1] = '{32'h0000_0000, pk(0, 0, 0, 0), 4'b0000, 4'b0000, 0};
    vecs[2] = '{32'h0000_0106, pk(1, 2, 8, 0), 4'b0111, 4'b0111, 0};
    vecs[3] = '{32'h0000_0000, pk(1, 2, 8, 0), 4'b0000, 4'b0000, 0};
    vecs[4] = '{32'h0000_000F, pk(0, 1, 2, 3), 4'b1111, 4'b1111, 0};
`ifdef VOICE_STEAL_EN
    vecs[5] = '{32'h0000_002F, pk(5, 1, 2, 3), 4'b1111, 4'b0001, 0};
    vecs[6] = '{32'h0000_022B, pk(5, 1, 9, 3), 4'b1111, 4'b0100, 0};
    vecs[7] = '{32'h0000_0000, pk(5, 1, 9, 3), 4'b0000, 4'b0000, 0};
`else
    vecs[5] = '{32'h0000_002F, pk(0, 1, 2, 3), 4'b1111, 4'b0000, 1};
    vecs[6] = '{32'h0000_022B, pk(0, 1, 9, 3), 4'b1111, 4'b0100, 0};
    vecs[7] = '{32'h0000_0000, pk(0, 1, 9, 3), 4'b0000, 4'b0000, 0};
`endif

    // Reset with no keys held: everything quiet, and it stays idle afterwards.
    rst_n     = 1'b0;
    bus.i_key = '0;
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
    idle_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.o_busy) idle_busy++;
    end
    chk("idle_busy_cycles", 64'(idle_busy), 64'h0);
    check_zero("post_reset");

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].key);
      chk($sformatf("v%0d_timeout", i), 64'(timed_out), 64'h0);
      chk($sformatf("v%0d_busy_cycles", i), 64'(busy_cnt), 64'd33);
      chk($sformatf("v%0d_voice_key", i), 64'(bus.o_voice_key), 64'(vecs[i].vkey));
      chk($sformatf("v%0d_gate", i), 64'(bus.o_voice_gate), 64'(vecs[i].gate));
      chk($sformatf("v%0d_note_mask", i), 64'(note_acc), 64'(vecs[i].note));
      chk($sformatf("v%0d_note_pulses", i), 64'(note_cnt), 64'($countones(vecs[i].note)));
      chk($sformatf("v%0d_drop_pulses", i), 64'(drop_cnt), 64'(vecs[i].drop));
      chk($sformatf("v%0d_idle_quiet", i), 64'({bus.o_note_on, bus.o_drop}), 64'h0);
      // Key k is examined in busy cycle k; its note_on is visible one cycle later.
      if (i == 0) chk("v0_note_cycle", 64'(note_cyc[0]), 64'd1);
      if (i == 2) begin
        chk("v2_note_cycle_k1", 64'(note_cyc[0]), 64'd2);
        chk("v2_note_cycle_k2", 64'(note_cyc[1]), 64'd3);
        chk("v2_note_cycle_k8", 64'(note_cyc[2]), 64'd9);
      end
    end

    // Reset in the middle of a scan that has already allocated keys 0 and 1.
    @(posedge clk);
    #1 bus.i_key = 32'h0000_0003;
    begin
      int w;
      w = 0;
      @(negedge clk);
      while (!bus.o_busy && w < 5) begin
        @(negedge clk);
        w++;
      end
      chk("midscan_busy_seen", 64'(bus.o_busy), 64'h1);
    end
    repeat (5) @(negedge clk);
    chk("midscan_gate_before", 64'(bus.o_voice_gate), 64'h3);
    chk("midscan_still_busy", 64'(bus.o_busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check_zero("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    apply(32'h0000_0003);
    chk("rescan_timeout", 64'(timed_out), 64'h0);
    chk("rescan_busy_cycles", 64'(busy_cnt), 64'd33);
    chk("rescan_voice_key", 64'(bus.o_voice_key), 64'(pk(0, 1, 0, 0)));
    chk("rescan_gate", 64'(bus.o_voice_gate), 64'h3);
    chk("rescan_note_mask", 64'(note_acc), 64'h3);
    chk("rescan_drop_pulses", 64'(drop_cnt), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
